// File: rtl/jt12_wrq_pkg.sv
// Shared definitions for the jt12 host write queue: FSM state codes and
// queue entry width ({addr[1:0], din[7:0]}).
package jt12_wrq_pkg;

  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_GAP       = 3'd2,
    ST_WAIT_RISE = 3'd3,
    ST_WAIT_FALL = 3'd4
  } state_e;

endpackage

// File: rtl/jt12_wrq_if.sv
// Register-file write port seen from the queue.
//   write : one-cycle write strobe
//   addr  : register-file address presented with write
//   din   : data presented with write
//   busy  : register file busy (rises the cycle after a data-write strobe)
// master = queue side (drives write/addr/din), slave = register-file side.
interface jt12_wrq_if;
  logic       write;
  logic [1:0] addr;
  logic [7:0] din;
  logic       busy;

  modport master (output write, output addr, output din, input busy);
  modport slave  (input write, input addr, input din, output busy);
endinterface

// File: rtl/jt12_fifo_sync.sv
// Generic single-clock FIFO, depth 2**AW.
//   push/din     : write side; push while full is ignored
//   pop/dout     : read side; dout shows the head entry, pop while empty ignored
//   full/empty   : status from current level (sampled before same-cycle pop)
//   level        : entries held (0..2**AW)
// rst flushes pointers and level; storage is not reset.
module jt12_fifo_sync #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 2**AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    empty    = (level_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/jt12_wrq.sv
// Host-side write queue in front of the jt12 register file.
// Buffers host writes {host_addr, host_din} and replays them on the
// register-file port (mmr) while respecting its busy flag.
//   clk, rst          : clock, synchronous active-high reset
//   host_wr/addr/din  : push one entry per cycle while high
//   host_full         : queue full, pushes dropped
//   host_ovf/host_clr : sticky drop flag and its clear (set wins)
//   level             : entries queued
//   idle              : queue empty, FSM idle and busy low
//   mmr               : register-file write port (registered outputs)
module jt12_wrq
  import jt12_wrq_pkg::*;
#(
  parameter int unsigned AW      = 4,
  parameter int unsigned TO_RISE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_din,
  output logic        host_full,
  output logic        host_ovf,
  input  logic        host_clr,
  output logic [AW:0] level,
  output logic        idle,
  jt12_wrq_if.master  mmr
);

  localparam int unsigned CW = $clog2(TO_RISE + 1);

  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               pop;

  state_e             state_q, state_d;
  logic [CW-1:0]      rise_cnt_q, rise_cnt_d;
  logic               write_q, write_d;
  logic [1:0]         addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic               ovf_q, ovf_d;

  jt12_fifo_sync #(
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_wr),
    .din   ({host_addr, host_din}),
    .pop   (pop),
    .dout  (head),
    .full  (host_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d    = state_q;
    rise_cnt_d = rise_cnt_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !mmr.busy) begin
          pop              = 1'b1;
          write_d          = 1'b1;
          {addr_d, din_d}  = head;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rise_cnt_d = '0;
        // Data writes (addr[0]=1) make the register file busy; address writes do not.
        state_d    = addr_q[0] ? ST_WAIT_RISE : ST_GAP;
      end
      ST_GAP: state_d = ST_IDLE;
      ST_WAIT_RISE: begin
        if (mmr.busy)                            state_d = ST_WAIT_FALL;
        else if (rise_cnt_q == CW'(TO_RISE - 1)) state_d = ST_IDLE;
        else                                     rise_cnt_d = rise_cnt_q + CW'(1);
      end
      ST_WAIT_FALL: begin
        if (!mmr.busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (host_clr)             ovf_d = 1'b0;
    if (host_wr && host_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rise_cnt_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rise_cnt_q <= rise_cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mmr.write = write_q;
  assign mmr.addr  = addr_q;
  assign mmr.din   = din_q;
  assign host_ovf  = ovf_q;
  assign idle      = fifo_empty && (state_q == ST_IDLE) && !mmr.busy;

endmodule

// File: tb/tb_jt12_wrq.sv
module tb_jt12_wrq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_wr = 1'b0;
  logic [1:0] host_addr = '0;
  logic [7:0] host_din = '0;
  logic       host_clr = 1'b0;
  logic       host_full;
  logic       host_ovf;
  logic [4:0] level;
  logic       idle;

  jt12_wrq_if mmr_if ();

  jt12_wrq #(.AW(4), .TO_RISE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_full (host_full),
    .host_ovf  (host_ovf),
    .host_clr  (host_clr),
    .level     (level),
    .idle      (idle),
    .mmr       (mmr_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Register-file busy model: busy high for busy_len cycles starting the
  // cycle after a data-write strobe, or while busy_hold is set.
  logic busy_hold = 1'b0;
  bit   busy_auto = 1'b1;
  int   busy_cnt  = 0;
  logic strobe_data;
  initial mmr_if.busy = 1'b0;
  always @(posedge clk) begin
    strobe_data = mmr_if.write && mmr_if.addr[0];
    #1;
    if (busy_auto && strobe_data) busy_cnt = 32;
    else if (busy_cnt != 0)       busy_cnt = busy_cnt - 1;
    mmr_if.busy = busy_hold || (busy_cnt != 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [9:0] log_q[$];
  int         cyc_q[$];
  logic       prev_w = 1'b0;
  int         wide_err = 0;
  always @(negedge clk) begin
    if (mmr_if.write) begin
      log_q.push_back({mmr_if.addr, mmr_if.din});
      cyc_q.push_back(cyc);
    end
    if (mmr_if.write && prev_w) wide_err++;
    prev_w = mmr_if.write;
  end

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (!idle && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [9:0] exp_q[$];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_full", host_full, 0);
    check("rst_ovf", host_ovf, 0);
    check("rst_write", mmr_if.write, 0);
    check("rst_addr", mmr_if.addr, 0);
    check("rst_din", mmr_if.din, 0);
    check("rst_idle", idle, 1);

    // Single address write: strobe 2 clocks after push, exactly 1 cycle wide
    rst = 1'b0;
    log_q.delete(); cyc_q.delete();
    host_wr = 1'b1; host_addr = 2'b00; host_din = 8'h28;
    @(negedge clk);
    host_wr = 1'b0;
    check("t1_level1", level, 1);
    check("t1_nostrobe", mmr_if.write, 0);
    @(negedge clk);
    check("t1_strobe", mmr_if.write, 1);
    check("t1_addr", mmr_if.addr, 0);
    check("t1_din", mmr_if.din, 8'h28);
    check("t1_level0", level, 0);
    @(negedge clk);
    check("t1_strobe_off", mmr_if.write, 0);
    check("t1_din_hold", mmr_if.din, 8'h28);
    wait_idle("t1_idle", 20);

    // Address, data, address with busy model active
    log_q.delete(); cyc_q.delete();
    busy_auto = 1'b1;
    host_wr = 1'b1; host_addr = 2'b00; host_din = 8'h28; @(negedge clk);
    host_addr = 2'b01; host_din = 8'hF0; @(negedge clk);
    host_addr = 2'b00; host_din = 8'h2B; @(negedge clk);
    host_wr = 1'b0;
    wait_idle("t2_idle", 200);
    check("t2_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t2_e0", log_q[0], {2'b00, 8'h28});
      check("t2_e1", log_q[1], {2'b01, 8'hF0});
      check("t2_e2", log_q[2], {2'b00, 8'h2B});
      check("t2_gap01", cyc_q[1] - cyc_q[0], 3);
      check("t2_gap12", cyc_q[2] - cyc_q[1], 35);
    end

    // Fill with busy held: 16 accepted, 17th dropped
    log_q.delete(); cyc_q.delete();
    busy_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      host_wr = 1'b1; host_addr = 2'b00; host_din = 8'(8'h40 + i);
      @(negedge clk);
    end
    check("t3_full", host_full, 1);
    check("t3_level16", level, 16);
    check("t3_ovf0", host_ovf, 0);
    host_din = 8'h99;
    @(negedge clk);
    host_wr = 1'b0;
    check("t3_ovf1", host_ovf, 1);
    check("t3_level_keep", level, 16);
    host_wr = 1'b1; host_clr = 1'b1;
    @(negedge clk);
    check("t3_set_wins", host_ovf, 1);
    host_wr = 1'b0;
    @(negedge clk);
    host_clr = 1'b0;
    check("t3_clr", host_ovf, 0);
    check("t3_no_issue", log_q.size(), 0);
    busy_hold = 1'b0;
    @(negedge clk);
    wait_idle("t3_idle", 200);
    check("t3_count", log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      check($sformatf("t3_e%0d", i), log_q[i], {2'b00, 8'(8'h40 + i)});
    check("t3_level0", level, 0);

    // Data write with busy never rising: timeout after 2 cycles
    log_q.delete(); cyc_q.delete();
    busy_auto = 1'b0;
    host_wr = 1'b1; host_addr = 2'b01; host_din = 8'hA5; @(negedge clk);
    host_addr = 2'b00; host_din = 8'h3C; @(negedge clk);
    host_wr = 1'b0;
    wait_idle("t4_idle", 50);
    check("t4_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_e1", log_q[1], {2'b00, 8'h3C});
      check("t4_gap", cyc_q[1] - cyc_q[0], 4);
    end

    // Reset while waiting for busy to fall with 5 entries queued
    log_q.delete(); cyc_q.delete();
    busy_auto = 1'b1;
    host_wr = 1'b1; host_addr = 2'b01; host_din = 8'h11; @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      host_addr = 2'b00; host_din = 8'(8'h50 + i); @(negedge clk);
    end
    host_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_level_pre", level, 5);
    check("t5_busy_pre", mmr_if.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_level0", level, 0);
    check("t5_write0", mmr_if.write, 0);
    wait_idle("t5_idle", 60);
    repeat (50) @(negedge clk);
    check("t5_count", log_q.size(), 1);

    // Push and pop in the same cycle at level 3
    log_q.delete(); cyc_q.delete();
    exp_q.delete();
    busy_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      host_wr = 1'b1; host_addr = 2'(i); host_din = 8'(8'h70 + i);
      exp_q.push_back({2'(i), 8'(8'h70 + i)});
      @(negedge clk);
    end
    host_wr = 1'b0;
    // keep entries as address writes only where addr[0]=0 matters little; busy_auto off
    busy_auto = 1'b0;
    @(negedge clk);
    check("t6_level3", level, 3);
    busy_hold = 1'b0;
    @(negedge clk);
    host_wr = 1'b1; host_addr = 2'b10; host_din = 8'h7F;
    exp_q.push_back({2'b10, 8'h7F});
    @(negedge clk);
    host_wr = 1'b0;
    check("t6_level_same", level, 3);
    check("t6_strobe", mmr_if.write, 1);
    check("t6_head", {mmr_if.addr, mmr_if.din}, {2'b00, 8'h70});
    wait_idle("t6_idle", 100);
    check("t6_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check($sformatf("t6_e%0d", i), log_q[i], exp_q[i]);

    check("strobe_width", wide_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
